vc_fifo: RTL and testbench

//   Multi-channel FIFO for NoC router input ports: NUM_VC independent virtual-channel queues share one

---
 rtl/vc_fifo.sv | 81 ++++++++
 tb/tb_vc_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC virtual-channel FIFOs sharing one storage array, one write and one read per cycle.
//   in : clk, rst (async, active-high), write/write_vc/data_in, read/read_vc
//   out: data_out (head of read_vc, fall-through), per-VC empty/full/almost_full/count,
//        sticky overflow/underflow
module vc_fifo #(
  parameter int WIDTH    = 18,
  parameter int DEPTH    = 16,
  parameter int NUM_VC   = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int VCW = $clog2(NUM_VC),
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [VCW-1:0]       write_vc,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 read,
  input  logic [VCW-1:0]       read_vc,
  output logic [WIDTH-1:0]     data_out,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*CW-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);
  logic [WIDTH-1:0] mem [NUM_VC*DEPTH];
  logic [AW-1:0] rd_ptr_q [NUM_VC];
  logic [AW-1:0] rd_ptr_d [NUM_VC];
  logic [AW-1:0] wr_ptr_q [NUM_VC];
  logic [AW-1:0] wr_ptr_d [NUM_VC];
  logic [CW-1:0] cnt_q [NUM_VC];
  logic [CW-1:0] cnt_d [NUM_VC];
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic read_acc, write_acc;
  logic [NUM_VC-1:0] rd_hit, wr_hit;
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign empty[i]           = cnt_q[i] == '0;
    assign full[i]            = cnt_q[i] == CW'(DEPTH);
    assign almost_full[i]     = cnt_q[i] >= CW'(AF_LEVEL);
    assign count[i*CW +: CW]  = cnt_q[i];
    assign rd_hit[i]          = read_acc && read_vc == VCW'(i);
    assign wr_hit[i]          = write_acc && write_vc == VCW'(i);
  end
  assign read_acc  = read & ~empty[read_vc];
  // a full VC still takes a write when the same VC is popped this cycle
  assign write_acc = write & (~full[write_vc] | (read_acc & (read_vc == write_vc)));
  assign data_out  = mem[{read_vc, rd_ptr_q[read_vc]}];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(rd_hit[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_hit[i]);
      cnt_d[i]    = (wr_hit[i] && !rd_hit[i]) ? cnt_q[i] + CW'(1) :
                    (rd_hit[i] && !wr_hit[i]) ? cnt_q[i] - CW'(1) : cnt_q[i];
    end
    overflow_d  = overflow_q | (write & ~write_acc);
    underflow_d = underflow_q | (read & ~read_acc);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (write_acc) mem[{write_vc, wr_ptr_q[write_vc]}] <= data_in;
endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: table, directed and randomized checks of vc_fifo against a queue-based model.
module tb_vc_fifo;
  localparam int N = 4, D = 16, CW = 5, AF = 14;
  logic clk = 1'b0, rst = 1'b1, write = 1'b0, read = 1'b0;
  logic [1:0] write_vc = '0, read_vc = '0;
  logic [17:0] data_in = '0, data_out;
  logic [N-1:0] empty, full, almost_full;
  logic [N*CW-1:0] count;
  logic overflow, underflow;
  int tests = 0, fails = 0;
  logic [17:0] mq [N][$];
  bit movf = 0, munf = 0;
  logic [17:0] dpre;

  vc_fifo dut (.clk(clk), .rst(rst), .write(write), .write_vc(write_vc), .data_in(data_in),
               .read(read), .read_vc(read_vc), .data_out(data_out), .empty(empty), .full(full),
               .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  typedef struct {
    bit w; int wvc; int din; bit r; int rvc;
    int exp_dout; int cvc; int exp_cnt; bit exp_ovf; bit exp_unf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int v);
    return count[v*CW +: CW];
  endfunction

  task automatic model_clear();
    for (int v = 0; v < N; v++) mq[v].delete();
    movf = 0;
    munf = 0;
  endtask

  task automatic model_check(input string nm);
    logic [N-1:0] ee, ef, ea;
    logic [N*CW-1:0] ec;
    for (int v = 0; v < N; v++) begin
      ee[v] = mq[v].size() == 0;
      ef[v] = mq[v].size() == D;
      ea[v] = mq[v].size() >= AF;
      ec[v*CW +: CW] = CW'(mq[v].size());
    end
    chk({nm, ".count"}, 32'(count), 32'(ec));
    chk({nm, ".empty"}, 32'(empty), 32'(ee));
    chk({nm, ".full"}, 32'(full), 32'(ef));
    chk({nm, ".afull"}, 32'(almost_full), 32'(ea));
    chk({nm, ".ovf"}, 32'(overflow), 32'(movf));
    chk({nm, ".unf"}, 32'(underflow), 32'(munf));
  endtask

  task automatic step(input bit w, input int wvc, input int din, input bit r, input int rvc,
                      output logic [17:0] dout);
    bit ra, wa;
    @(negedge clk);
    write = w; write_vc = 2'(wvc); data_in = 18'(din);
    read = r; read_vc = 2'(rvc);
    #1;
    dout = data_out;
    if (mq[rvc].size() > 0) chk("model.dout", 32'(data_out), 32'(mq[rvc][0]));
    ra = r && mq[rvc].size() > 0;
    wa = w && (mq[wvc].size() < D || (ra && rvc == wvc));
    if (r && !ra) munf = 1;
    if (w && !wa) movf = 1;
    if (ra) void'(mq[rvc].pop_front());
    if (wa) mq[wvc].push_back(18'(din));
    @(posedge clk);
    #1;
    model_check("model");
    write = 1'b0;
    read = 1'b0;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1; write = 1'b0; read = 1'b0;
    #1;
    model_clear();
    model_check("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_vc2();
    for (int i = 0; i < D; i++) begin
      step(1, 2, 'h100 + i, 0, 0, dpre);
      chk("fill.afull2", 32'(almost_full[2]), 32'(i + 1 >= AF));
    end
    chk("fill.full2", 32'(full[2]), 32'd1);
    chk("fill.cnt2", 32'(cnt_of(2)), 32'd16);
  endtask

  vec_t tbl [13];

  initial begin
    #1;
    model_check("reset");
    chk("reset.empty", 32'(empty), 32'hF);
    @(negedge clk);
    rst = 1'b0;

    // fill VC2, overflow, drain in order
    fill_vc2();
    step(1, 2, 'h1FF, 0, 0, dpre);
    chk("fill.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < D; i++) begin
      step(0, 0, 0, 1, 2, dpre);
      chk("drain.dout", 32'(dpre), 32'('h100 + i));
    end
    chk("drain.empty2", 32'(empty[2]), 32'd1);

    // full VC2, simultaneous read+write
    reset_all();
    fill_vc2();
    step(1, 2, 'h2AA, 1, 2, dpre);
    chk("fullrw.dout", 32'(dpre), 32'h100);
    chk("fullrw.cnt2", 32'(cnt_of(2)), 32'd16);
    chk("fullrw.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < D - 1; i++) step(0, 0, 0, 1, 2, dpre);
    step(0, 0, 0, 1, 2, dpre);
    chk("fullrw.last", 32'(dpre), 32'h2AA);

    // table: empty same-VC read+write, interleave, cross-VC concurrency
    reset_all();
    tbl[0]  = '{1, 1, 'h055, 1, 1, -1,     1, 1, 0, 1};
    tbl[1]  = '{0, 0, 0,     1, 1, 'h055, 1, 0, 0, 1};
    tbl[2]  = '{1, 0, 'h011, 0, 0, -1,     0, 1, 0, 1};
    tbl[3]  = '{1, 3, 'h033, 0, 0, -1,     3, 1, 0, 1};
    tbl[4]  = '{1, 0, 'h012, 0, 0, -1,     0, 2, 0, 1};
    tbl[5]  = '{0, 0, 0,     1, 3, 'h033, 3, 0, 0, 1};
    tbl[6]  = '{0, 0, 0,     1, 0, 'h011, 0, 1, 0, 1};
    tbl[7]  = '{0, 0, 0,     1, 0, 'h012, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 'h021, 0, 0, -1,     0, 1, 0, 1};
    tbl[9]  = '{1, 3, 'h034, 1, 0, 'h021, 3, 1, 0, 1};
    tbl[10] = '{1, 3, 'h035, 1, 0, -1,     0, 0, 0, 1};
    tbl[11] = '{0, 0, 0,     1, 3, 'h034, 3, 1, 0, 1};
    tbl[12] = '{0, 0, 0,     1, 3, 'h035, 3, 0, 0, 1};
    for (int k = 0; k < 13; k++) begin
      step(tbl[k].w, tbl[k].wvc, tbl[k].din, tbl[k].r, tbl[k].rvc, dpre);
      if (tbl[k].exp_dout >= 0) chk($sformatf("tbl%0d.dout", k), 32'(dpre), 32'(tbl[k].exp_dout));
      chk($sformatf("tbl%0d.cnt", k), 32'(cnt_of(tbl[k].cvc)), 32'(tbl[k].exp_cnt));
      chk($sformatf("tbl%0d.ovf", k), 32'(overflow), 32'(tbl[k].exp_ovf));
      chk($sformatf("tbl%0d.unf", k), 32'(underflow), 32'(tbl[k].exp_unf));
    end

    // pointer wrap on VC0 at occupancy 3, then reset mid-traffic
    reset_all();
    for (int i = 0; i < 3; i++) step(1, 0, 'h300 + i, 0, 0, dpre);
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 'h303 + k, 1, 0, dpre);
      chk("wrap.dout", 32'(dpre), 32'('h300 + k));
      chk("wrap.cnt0", 32'(cnt_of(0)), 32'd3);
    end
    @(negedge clk);
    write = 1'b1; write_vc = 2'd0; data_in = 18'h3FF; read = 1'b1; read_vc = 2'd0; rst = 1'b1;
    #1;
    chk("midrst.empty", 32'(empty), 32'hF);
    chk("midrst.count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst.hold", 32'(count), 32'd0);
    write = 1'b0; read = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_check("postrst");

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      int wp, rp;
      wp = (n % 600) < 300 ? 80 : 35;
      rp = (n % 600) < 300 ? 30 : 75;
      step($urandom_range(99) < wp, $urandom_range(3), $urandom_range(18'h3FFFF),
           $urandom_range(99) < rp, $urandom_range(3), dpre);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
